// File: rtl/sdram_rw_sched.sv
// sdram_rw_sched: two-client round-robin scheduler in front of the SDRAM
// read/write controller. Latches one burst request at a time, fires a single
// wr/rd trigger and tracks completion through the controller end flags, with
// a sticky watchdog error if the controller never reports back.
module sdram_rw_sched #(
  parameter int ROW_W   = 12,
  parameter int COL_W   = 9,
  parameter int TIMEOUT = 1023
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             init_done,
  input  logic             c0_req,
  input  logic             c0_we,
  input  logic [1:0]       c0_bank,
  input  logic [ROW_W-1:0] c0_row,
  input  logic [COL_W-1:0] c0_col,
  output logic             c0_ack,
  output logic             c0_done,
  input  logic             c1_req,
  input  logic             c1_we,
  input  logic [1:0]       c1_bank,
  input  logic [ROW_W-1:0] c1_row,
  input  logic [COL_W-1:0] c1_col,
  output logic             c1_ack,
  output logic             c1_done,
  output logic             wr_trig,
  output logic             rd_trig,
  output logic [1:0]       cmd_bank,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  input  logic             flag_wr_end,
  input  logic             flag_rd_end,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [4:0] {
    WAIT_INIT = 5'b00001,
    IDLE      = 5'b00010,
    ISSUE     = 5'b00100,
    WAIT_END  = 5'b01000,
    DONE      = 5'b10000
  } state_t;

  // Last watchdog count before the burst is abandoned.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;       // client favoured when both request
  logic               owner_q, owner_d;   // client owning the current burst
  logic               we_q, we_d;
  logic [1:0]         bank_q, bank_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [15:0]        wd_q, wd_d;
  logic               err_q, err_d;

  logic               wr_trig_q, wr_trig_d;
  logic               rd_trig_q, rd_trig_d;
  logic               c0_ack_q, c0_ack_d;
  logic               c1_ack_q, c1_ack_d;
  logic               c0_done_q, c0_done_d;
  logic               c1_done_q, c1_done_d;
  logic               busy_q, busy_d;

  logic               grant_id;
  logic               end_match;

  // Next-state, arbitration, request latching and watchdog.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    we_d      = we_q;
    bank_d    = bank_q;
    row_d     = row_q;
    col_d     = col_q;
    wd_d      = wd_q;
    err_d     = err_q;
    grant_id  = 1'b0;
    // Only the end flag matching the burst direction completes it.
    end_match = we_q ? flag_wr_end : flag_rd_end;

    case (state_q)
      WAIT_INIT: begin
        if (init_done) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (c0_req || c1_req) begin
          // With a single requester it wins outright; with two the pointer decides.
          grant_id = (c0_req && c1_req) ? ptr_q : c1_req;
          owner_d  = grant_id;
          if (grant_id) begin
            we_d   = c1_we;
            bank_d = c1_bank;
            row_d  = c1_row;
            col_d  = c1_col;
          end else begin
            we_d   = c0_we;
            bank_d = c0_bank;
            row_d  = c0_row;
            col_d  = c0_col;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Hand priority to the other client so continuous contention alternates.
        ptr_d   = ~owner_q;
        wd_d    = '0;
        state_d = WAIT_END;
      end
      WAIT_END: begin
        if (end_match) begin
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = WAIT_INIT;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    wr_trig_d = (state_d == ISSUE) && we_d;
    rd_trig_d = (state_d == ISSUE) && !we_d;
    c0_ack_d  = (state_d == ISSUE) && !owner_d;
    c1_ack_d  = (state_d == ISSUE) && owner_d;
    c0_done_d = (state_d == DONE) && !owner_d;
    c1_done_d = (state_d == DONE) && owner_d;
    busy_d    = (state_d == ISSUE) || (state_d == WAIT_END) || (state_d == DONE);
  end

  // Control state: FSM, arbitration pointer, owner and watchdog.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= WAIT_INIT;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Latched command address and registered pulse outputs.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      bank_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wr_trig_q <= 1'b0;
      rd_trig_q <= 1'b0;
      c0_ack_q  <= 1'b0;
      c1_ack_q  <= 1'b0;
      c0_done_q <= 1'b0;
      c1_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_trig_q <= wr_trig_d;
      rd_trig_q <= rd_trig_d;
      c0_ack_q  <= c0_ack_d;
      c1_ack_q  <= c1_ack_d;
      c0_done_q <= c0_done_d;
      c1_done_q <= c1_done_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_trig     = wr_trig_q;
  assign rd_trig     = rd_trig_q;
  assign c0_ack      = c0_ack_q;
  assign c1_ack      = c1_ack_q;
  assign c0_done     = c0_done_q;
  assign c1_done     = c1_done_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign cmd_bank    = bank_q;
  assign cmd_row     = row_q;
  assign cmd_col     = col_q;

endmodule

// File: tb/tb_sdram_rw_sched.sv
// Testbench for sdram_rw_sched: scoreboard of expected issues/dones fed by a
// request-level model of the two clients and the round-robin rule.
module tb_sdram_rw_sched;
  localparam int ROW_W   = 12;
  localparam int COL_W   = 9;
  localparam int TIMEOUT = 8;

  logic             sclk = 1'b0;
  logic             s_rst_n = 1'b0;
  logic             init_done = 1'b0;
  logic             c0_req = 1'b0, c0_we = 1'b0;
  logic [1:0]       c0_bank = '0;
  logic [ROW_W-1:0] c0_row = '0;
  logic [COL_W-1:0] c0_col = '0;
  logic             c1_req = 1'b0, c1_we = 1'b0;
  logic [1:0]       c1_bank = '0;
  logic [ROW_W-1:0] c1_row = '0;
  logic [COL_W-1:0] c1_col = '0;
  logic             flag_wr_end = 1'b0, flag_rd_end = 1'b0;
  logic             c0_ack, c0_done, c1_ack, c1_done;
  logic             wr_trig, rd_trig, busy, timeout_err;
  logic [1:0]       cmd_bank;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;

  sdram_rw_sched #(.ROW_W(ROW_W), .COL_W(COL_W), .TIMEOUT(TIMEOUT)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .init_done(init_done),
    .c0_req(c0_req), .c0_we(c0_we), .c0_bank(c0_bank), .c0_row(c0_row), .c0_col(c0_col),
    .c0_ack(c0_ack), .c0_done(c0_done),
    .c1_req(c1_req), .c1_we(c1_we), .c1_bank(c1_bank), .c1_row(c1_row), .c1_col(c1_col),
    .c1_ack(c1_ack), .c1_done(c1_done),
    .wr_trig(wr_trig), .rd_trig(rd_trig),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .flag_wr_end(flag_wr_end), .flag_rd_end(flag_rd_end),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic             owner;
    logic             we;
    logic [1:0]       bank;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } req_t;

  req_t issue_q[$];
  int   done_q[$];
  int   errors = 0;
  int   checks = 0;

  // Request-level model: who is asking, with what, and whose turn it is.
  bit   pend [2];
  req_t pend_r [2];
  int   model_ptr = 0;

  req_t mon_e;
  int   mon_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic req_t rand_req(input logic owner);
    req_t r;
    r.owner = owner;
    r.we    = 1'($urandom_range(0, 1));
    r.bank  = 2'($urandom_range(0, 3));
    r.row   = ROW_W'($urandom);
    r.col   = COL_W'($urandom);
    return r;
  endfunction

  task automatic drive();
    c0_req = pend[0]; c0_we = pend_r[0].we; c0_bank = pend_r[0].bank;
    c0_row = pend_r[0].row; c0_col = pend_r[0].col;
    c1_req = pend[1]; c1_we = pend_r[1].we; c1_bank = pend_r[1].bank;
    c1_row = pend_r[1].row; c1_col = pend_r[1].col;
  endtask

  // Lone requester wins; with two, the one whose turn it is wins, and the turn passes.
  task automatic model_grant(output int w);
    if (pend[0] && pend[1]) w = model_ptr;
    else if (pend[1])       w = 1;
    else                    w = 0;
    issue_q.push_back(pend_r[w]);
    model_ptr = 1 - w;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge sclk);
      if (c0_ack || c1_ack) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ack_wait: no ack within 40 cycles, expected one");
    end
  endtask

  // Entered at the ISSUE-cycle negedge; completes the burst and returns at an IDLE negedge.
  task automatic finish_burst(input int w, input bit issue_flag, input bit wrong,
                              input int d, input bit rearm);
    req_t r;
    r = pend_r[w];
    pend[w] = 1'b0;
    if (rearm) begin
      pend[w]   = 1'b1;
      pend_r[w] = rand_req(w[0]);
    end
    drive();
    if (issue_flag) begin
      if (r.we) flag_wr_end = 1'b1; else flag_rd_end = 1'b1;
    end
    @(negedge sclk);
    flag_wr_end = 1'b0; flag_rd_end = 1'b0;
    repeat (d) @(negedge sclk);
    if (wrong) begin
      if (r.we) flag_rd_end = 1'b1; else flag_wr_end = 1'b1;
      @(negedge sclk);
      flag_wr_end = 1'b0; flag_rd_end = 1'b0;
      check("wrong_flag_ignored", {busy, c0_done, c1_done}, 3'b100);
    end
    if (r.we) flag_wr_end = 1'b1; else flag_rd_end = 1'b1;
    done_q.push_back(w);
    @(negedge sclk);
    flag_wr_end = 1'b0; flag_rd_end = 1'b0;
    check("done_and_cmd_hold", {c0_done, c1_done, cmd_bank, cmd_row, cmd_col},
          {(w == 0), (w == 1), r.bank, r.row, r.col});
    @(negedge sclk);
    check("idle_after_done", {busy, c0_done, c1_done}, 3'b000);
  endtask

  task automatic serve(input bit rearm, input bit issue_flag, input bit wrong, input int d);
    int w;
    bit ok;
    model_grant(w);
    wait_ack(ok);
    if (!ok) finish_sim();
    finish_burst(w, issue_flag, wrong, d, rearm);
  endtask

  // Monitor: every issue or done the DUT shows is matched against the scoreboard.
  always @(negedge sclk) begin
    if (s_rst_n) begin
      if (wr_trig || rd_trig || c0_ack || c1_ack) begin
        if (issue_q.size() == 0) begin
          check("spurious_issue", {wr_trig, rd_trig, c0_ack, c1_ack}, 4'b0000);
        end else begin
          mon_e = issue_q.pop_front();
          $display("issue owner=%0d we=%0d bank=%0d row=%h col=%h",
                   c1_ack, wr_trig, cmd_bank, cmd_row, cmd_col);
          check("issue", {wr_trig, rd_trig, c0_ack, c1_ack, cmd_bank, cmd_row, cmd_col},
                {mon_e.we, !mon_e.we, !mon_e.owner, mon_e.owner, mon_e.bank, mon_e.row, mon_e.col});
        end
      end
      if (c0_done || c1_done) begin
        if (done_q.size() == 0) begin
          check("spurious_done", {c0_done, c1_done}, 2'b00);
        end else begin
          mon_d = done_q.pop_front();
          $display("done owner=%0d", c1_done);
          check("done", {c0_done, c1_done}, {(mon_d == 0), (mon_d == 1)});
        end
      end
    end
  end

  initial begin
    #1000000;
    checks++;
    errors++;
    $display("FAIL global_time: simulation still running, expected completion");
    finish_sim();
  end

  initial begin
    int  w;
    bit  ok;
    bit  acc;

    // Reset values.
    repeat (3) @(negedge sclk);
    check("reset_outputs", {c0_ack, c0_done, c1_ack, c1_done, wr_trig, rd_trig, busy,
                            timeout_err, cmd_bank, cmd_row, cmd_col}, '0);
    s_rst_n = 1'b1;

    // Init gate with a pending c0 write carrying known fields.
    pend_r[0] = '{owner: 1'b0, we: 1'b1, bank: 2'd2, row: 12'h123, col: 9'h045};
    pend_r[1] = rand_req(1'b1);
    pend[0] = 1'b1;
    drive();
    acc = 1'b0;
    repeat (50) begin
      @(negedge sclk);
      acc |= c0_ack | c1_ack | wr_trig | rd_trig | busy;
    end
    check("init_gate", acc, 1'b0);
    model_grant(w);
    init_done = 1'b1;
    @(negedge sclk);
    check("init_plus_1", {wr_trig, c0_ack}, 2'b00);
    @(negedge sclk);
    check("init_plus_2", {wr_trig, c0_ack, c1_ack, rd_trig}, 4'b1100);
    finish_burst(w, 1'b0, 1'b0, 1, 1'b0);

    // Contention: both keep requesting, grants must alternate.
    pend[0] = 1'b1; pend_r[0] = rand_req(1'b0);
    pend[1] = 1'b1; pend_r[1] = rand_req(1'b1);
    drive();
    for (int i = 0; i < 4; i++) serve(1'b1, 1'b0, 1'b0, $urandom_range(0, 2));
    while (pend[0] || pend[1]) serve(1'b0, 1'b0, 1'b0, 0);

    // Wrong flag on a c1 read, also with an end flag during ISSUE.
    pend[1] = 1'b1; pend_r[1] = rand_req(1'b1); pend_r[1].we = 1'b0;
    drive();
    serve(1'b0, 1'b1, 1'b1, 1);

    // Watchdog: c0 read never completed.
    pend[0] = 1'b1; pend_r[0] = rand_req(1'b0); pend_r[0].we = 1'b0;
    drive();
    model_grant(w);
    wait_ack(ok);
    if (!ok) finish_sim();
    pend[0] = 1'b0;
    drive();
    repeat (TIMEOUT) @(negedge sclk);
    check("wd_last_cycle", {timeout_err, busy}, 2'b01);
    @(negedge sclk);
    check("wd_expired", {timeout_err, busy}, 2'b10);
    pend[1] = 1'b1; pend_r[1] = rand_req(1'b1);
    drive();
    serve(1'b0, 1'b0, 1'b0, 2);
    check("err_sticky", timeout_err, 1'b1);

    // Reset in the middle of a c1 read.
    pend[1] = 1'b1; pend_r[1] = rand_req(1'b1); pend_r[1].we = 1'b0;
    drive();
    model_grant(w);
    wait_ack(ok);
    if (!ok) finish_sim();
    pend[1] = 1'b0;
    drive();
    @(negedge sclk);
    #2 s_rst_n = 1'b0;
    init_done = 1'b0;
    #1;
    check("reset_mid_burst", {c0_ack, c0_done, c1_ack, c1_done, wr_trig, rd_trig, busy,
                              timeout_err, cmd_bank, cmd_row, cmd_col}, '0);
    model_ptr = 0;
    @(negedge sclk);
    @(negedge sclk);
    s_rst_n = 1'b1;
    pend[1] = 1'b1; pend_r[1] = rand_req(1'b1);
    drive();
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      flag_rd_end = (i == 3);
      flag_wr_end = (i == 4);
      @(negedge sclk);
      acc |= c0_ack | c1_ack | c0_done | c1_done | busy;
    end
    flag_rd_end = 1'b0; flag_wr_end = 1'b0;
    check("wait_init_after_reset", acc, 1'b0);
    init_done = 1'b1;
    serve(1'b0, 1'b0, 1'b0, 1);
    check("err_cleared_by_reset", timeout_err, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
          pend[c]   = 1'b1;
          pend_r[c] = rand_req(c[0]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        w = int'($urandom_range(0, 1));
        pend[w]   = 1'b1;
        pend_r[w] = rand_req(w[0]);
      end
      drive();
      serve(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end
    while (pend[0] || pend[1]) serve(1'b0, 1'b0, 1'b0, 0);

    repeat (5) @(negedge sclk);
    check("issue_queue_drained", issue_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    finish_sim();
  end

endmodule

// File: doc/sdram_rw_sched.md
# sdram_rw_sched

Two-client request scheduler in front of the SDRAM read/write controller. Accepts burst read/write requests from two clients and arbitrates round-robin between them. Drives one `wr_trig`/`rd_trig` pulse per granted request, with a latched bank/row/column. Tracks completion through the controller's end flags and reports per-client ack/done, plus a sticky watchdog error.

## Interface
- `ROW_W`, 12: row address width.
- `COL_W`, 9: column address width.
- `TIMEOUT`, 1023: max cycles in WAIT_END before abort; legal 2..65535.
- `sclk`  in  1  system clock; everything is synchronous to its rising edge.
- `s_rst_n`  in  1  asynchronous, active-low reset.
- `init_done`  in  1  SDRAM init complete; level.
- `cN_req`  in  1  client N request, level, held until `cN_ack` (N = 0, 1).
- `cN_we`  in  1  1 = write, 0 = read; stable while `cN_req` is high.
- `cN_bank`  in  2  bank; stable while `cN_req` is high.
- `cN_row`  in  ROW_W  row; stable while `cN_req` is high.
- `cN_col`  in  COL_W  column; stable while `cN_req` is high.
- `cN_ack`  out  1  one-cycle pulse: request accepted, fields may change.
- `cN_done`  out  1  one-cycle pulse: burst finished.
- `wr_trig`  out  1  one-cycle write start pulse to the controller.
- `rd_trig`  out  1  one-cycle read start pulse to the controller.
- `cmd_bank`  out  2  latched bank for the current burst.
- `cmd_row`  out  ROW_W  latched row for the current burst.
- `cmd_col`  out  COL_W  latched column for the current burst.
- `flag_wr_end`  in  1  controller write-complete pulse.
- `flag_rd_end`  in  1  controller read-complete pulse.
- `busy`  out  1  high in every state except IDLE and WAIT_INIT.
- `timeout_err`  out  1  sticky watchdog error; cleared only by reset.

## Operation
- FSM states: WAIT_INIT, IDLE, ISSUE, WAIT_END, DONE. One-hot encoding; an illegal state goes to WAIT_INIT.
- WAIT_INIT: go to IDLE once `init_done` = 1. No requests are acked before that.
- IDLE, no request pending: stay in IDLE.
- IDLE, exactly one `cN_req` high: grant that client.
- IDLE, both `cN_req` high: grant the client selected by priority pointer `ptr`.
- On grant: latch `cN_we`, `cN_bank`, `cN_row`, `cN_col` and the owner id, then go to ISSUE.
- ISSUE, one cycle only:
  - Assert `wr_trig` if the latched we = 1, otherwise `rd_trig`.
  - Assert the owner's `cN_ack`.
  - Set `ptr` to the client that was not granted.
  - Go to WAIT_END.
- WAIT_END: wait for the matching end flag (`flag_wr_end` for a write, `flag_rd_end` for a read). Ignore the non-matching flag.
- Matching flag seen in WAIT_END: go to DONE.
- Watchdog: counter `wd` clears on entry to WAIT_END and increments each WAIT_END cycle. If `wd` reaches TIMEOUT-1 with no matching flag:
  - Set `timeout_err`.
  - Go to IDLE with no `cN_done` pulse.
- DONE, one cycle: pulse the owner's `cN_done`, then go to IDLE.
- `cmd_*` hold their latched values from ISSUE until the next grant. They are never zeroed between bursts.
- `init_done` falling after WAIT_INIT is ignored; the FSM does not return to WAIT_INIT.

## Timing
- Reset values:
  - State = WAIT_INIT, `ptr` = 0 (client 0 first), `wd` = 0.
  - Every output = 0: `cN_ack`, `cN_done`, `wr_trig`, `rd_trig`, `cmd_*`, `busy`, `timeout_err`.
- Assertion of `s_rst_n` mid-burst forces all of the above immediately. No pending trig or done is emitted afterwards.
- All outputs are registered.
- Request high in IDLE at edge N: trig, ack and valid `cmd_*` are high during cycle N+1 (ISSUE).
- Matching end flag sampled at edge M in WAIT_END: `cN_done` is high during cycle M+1.
- Next grant is possible at the edge after DONE. Minimum request-to-request spacing is 4 cycles plus controller latency.
- An end flag that coincides with the ISSUE cycle is ignored. It is only counted in WAIT_END.
- A request dropped before ack is simply not served. This is legal only while in IDLE; otherwise the behaviour is undefined.
- Both clients requesting continuously are served strictly alternately, so neither client starves.

## Test plan
- Init gate: `init_done` = 0 for 50 cycles with `c0_req` = 1 -> no `c0_ack`, no trig. `init_done` rises -> `wr_trig` and `c0_ack` exactly 2 cycles later.
- Single write: `c0_req`, we = 1, bank = 2, row = 0x123, col = 0x045 -> one `wr_trig` with `cmd_bank` = 2, `cmd_row` = 0x123, `cmd_col` = 0x045. `flag_wr_end` pulse -> `c0_done` one cycle later; `c1_done` stays 0.
- Contention: c0 and c1 both request continuously for 4 bursts -> grant order c0, c1, c0, c1, with exactly one trig per grant.
- Wrong flag: c1 read in flight, inject `flag_wr_end` -> stays in WAIT_END. Then `flag_rd_end` -> `c1_done`.
- Timeout: TIMEOUT = 8, no end flag -> `timeout_err` = 1 after 8 WAIT_END cycles, no `cN_done`, back in IDLE. A next request is still served and the error stays set.
- Reset mid-burst: `s_rst_n` low in WAIT_END -> all outputs 0 immediately. After release, no `cN_done` appears and the FSM is in WAIT_INIT.
